// File: rtl/dmem_pkg.sv
// Shared definitions for the data-memory bus interface: size encodings,
// FSM state encoding and the access legality check.
package dmem_pkg;

   localparam logic [1:0] SZ_B = 2'b00;
   localparam logic [1:0] SZ_H = 2'b01;
   localparam logic [1:0] SZ_W = 2'b10;
   localparam logic [1:0] SZ_D = 2'b11;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_ACCESS = 2'd1,
      ST_RESP   = 2'd2
   } state_t;

   // Returns 1 when the access is misaligned for its size, or is a double
   // access on a 32-bit bus.
   function automatic logic dmem_bad_access(input logic [1:0] size,
                                            input logic [2:0] addr_lo,
                                            input logic       is_64);
      logic bad;
      bad = 1'b0;
      case (size)
         SZ_B:    bad = 1'b0;
         SZ_H:    bad = addr_lo[0];
         SZ_W:    bad = |addr_lo[1:0];
         SZ_D:    bad = ~is_64 | (|addr_lo[2:0]);
         default: bad = 1'b1;
      endcase
      return bad;
   endfunction

endpackage

// File: rtl/dmem_lane_align.sv
// Byte-lane steering: load extract with sign/zero extension, and store
// data replication across all lanes of the bus.
module dmem_lane_align #(
   parameter int XLEN = 32
) (
   input  logic [1:0]                  i_st_size,
   input  logic [XLEN-1:0]             i_st_data,
   output logic [XLEN-1:0]             o_st_data,
   input  logic [1:0]                  i_ld_size,
   input  logic [$clog2(XLEN/8)-1:0]   i_ld_off,
   input  logic                        i_ld_unsigned,
   input  logic [XLEN-1:0]             i_ld_data,
   output logic [XLEN-1:0]             o_ld_data
);
   import dmem_pkg::*;

   logic [XLEN-1:0] w_shift;
   logic [XLEN-1:0] w_mask;
   logic            w_sign;

   // Store replication: the bus samples whichever lane the address selects.
   always_comb begin
      o_st_data = i_st_data;
      case (i_st_size)
         SZ_B:    o_st_data = {(XLEN/8){i_st_data[7:0]}};
         SZ_H:    o_st_data = {(XLEN/16){i_st_data[15:0]}};
         SZ_W:    o_st_data = {(XLEN/32){i_st_data[31:0]}};
         default: o_st_data = i_st_data;
      endcase
   end

   // Load extraction: shift the addressed lane down, then mask and extend.
   always_comb begin
      w_shift = i_ld_data >> {i_ld_off, 3'b000};
      w_mask  = {XLEN{1'b1}};
      w_sign  = 1'b0;
      case (i_ld_size)
         SZ_B: begin
            w_mask = XLEN'(8'hFF);
            w_sign = w_shift[7];
         end
         SZ_H: begin
            w_mask = XLEN'(16'hFFFF);
            w_sign = w_shift[15];
         end
         SZ_W: begin
            w_mask = XLEN'(32'hFFFF_FFFF);
            w_sign = w_shift[31];
         end
         default: begin
            w_mask = {XLEN{1'b1}};
            w_sign = 1'b0;
         end
      endcase
      o_ld_data = (w_shift & w_mask) |
                  ({XLEN{w_sign & ~i_ld_unsigned}} & ~w_mask);
   end

endmodule

// File: rtl/dmem_bus_if.sv
// MEM-stage data bus interface: request latch, ACKD_n handshake with wait
// states and timeout, misalignment rejection and pipeline stall.
module dmem_bus_if #(
   parameter int XLEN    = 32,
   parameter int AW      = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              req_valid,
   input  logic              req_write,
   input  logic [1:0]        req_size,
   input  logic              req_unsigned,
   input  logic [AW-1:0]     req_addr,
   input  logic [XLEN-1:0]   req_wdata,
   output logic              stall,
   output logic              resp_valid,
   output logic [XLEN-1:0]   resp_rdata,
   output logic              resp_err,
   output logic [AW-1:0]     DAD,
   output logic [XLEN-1:0]   ddt_o,
   output logic              ddt_oe,
   input  logic [XLEN-1:0]   ddt_i,
   output logic              MREQ,
   output logic              WRITE,
   output logic [1:0]        SIZE,
   input  logic              ACKD_n
);
   import dmem_pkg::*;

   localparam int LB = $clog2(XLEN/8);
   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);

   state_t            r_state;
   state_t            w_next_state;
   logic [CW-1:0]     r_cnt;
   logic [LB-1:0]     r_addr_lo;
   logic [1:0]        r_size;
   logic              r_write;
   logic              r_unsigned;
   logic [AW-1:0]     r_dad;
   logic [XLEN-1:0]   r_ddt_o;
   logic              r_mreq;
   logic              r_bus_write;
   logic              r_ddt_oe;
   logic              r_resp_valid;
   logic              r_resp_err;
   logic [XLEN-1:0]   r_resp_rdata;

   logic              w_bad;
   logic              w_ack;
   logic              w_timeout;
   logic [XLEN-1:0]   w_st_data;
   logic [XLEN-1:0]   w_ld_data;

   assign w_bad = dmem_bad_access(req_size, req_addr[2:0], (XLEN == 64));

   dmem_lane_align #(.XLEN(XLEN)) u_align (
      .i_st_size     (req_size),
      .i_st_data     (req_wdata),
      .o_st_data     (w_st_data),
      .i_ld_size     (r_size),
      .i_ld_off      (r_addr_lo),
      .i_ld_unsigned (r_unsigned),
      .i_ld_data     (ddt_i),
      .o_ld_data     (w_ld_data)
   );

   // FSM state register.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_next_state;
      end
   end

   // Next-state logic; acknowledge wins over a coincident timeout.
   always_comb begin
      w_next_state = r_state;
      w_ack        = 1'b0;
      w_timeout    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            if (req_valid) begin
               w_next_state = w_bad ? ST_RESP : ST_ACCESS;
            end else begin
               w_next_state = ST_IDLE;
            end
         end
         ST_ACCESS: begin
            w_ack     = ~ACKD_n;
            w_timeout = (TIMEOUT != 0) && (r_cnt == CW'(TIMEOUT - 1));
            if (w_ack || w_timeout) begin
               w_next_state = ST_RESP;
            end else begin
               w_next_state = ST_ACCESS;
            end
         end
         ST_RESP: w_next_state = ST_IDLE;
         default: w_next_state = ST_IDLE;
      endcase
   end

   // Request latch, bus outputs, wait counter and response registers.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_cnt        <= '0;
         r_addr_lo    <= '0;
         r_size       <= 2'b00;
         r_write      <= 1'b0;
         r_unsigned   <= 1'b0;
         r_dad        <= '0;
         r_ddt_o      <= '0;
         r_mreq       <= 1'b0;
         r_bus_write  <= 1'b0;
         r_ddt_oe     <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         r_resp_rdata <= '0;
      end else begin
         r_resp_valid <= 1'b0;
         r_resp_err   <= 1'b0;
         case (r_state)
            ST_IDLE: begin
               if (req_valid) begin
                  r_addr_lo    <= req_addr[LB-1:0];
                  r_size       <= req_size;
                  r_write      <= req_write;
                  r_unsigned   <= req_unsigned;
                  r_dad        <= {req_addr[AW-1:LB], {LB{1'b0}}};
                  r_ddt_o      <= req_write ? w_st_data : '0;
                  r_cnt        <= '0;
                  r_resp_rdata <= '0;
                  if (w_bad) begin
                     r_resp_valid <= 1'b1;
                     r_resp_err   <= 1'b1;
                  end else begin
                     r_mreq      <= 1'b1;
                     r_bus_write <= req_write;
                     r_ddt_oe    <= req_write;
                  end
               end
            end
            ST_ACCESS: begin
               if (w_ack || w_timeout) begin
                  r_mreq       <= 1'b0;
                  r_bus_write  <= 1'b0;
                  r_ddt_oe     <= 1'b0;
                  r_resp_valid <= 1'b1;
                  r_resp_err   <= ~w_ack;
                  r_resp_rdata <= (w_ack && !r_write) ? w_ld_data : '0;
               end else if (TIMEOUT != 0) begin
                  r_cnt <= r_cnt + CW'(1);
               end
            end
            ST_RESP: begin
               r_resp_rdata <= '0;
            end
            default: begin
               r_mreq      <= 1'b0;
               r_bus_write <= 1'b0;
               r_ddt_oe    <= 1'b0;
            end
         endcase
      end
   end

   assign stall      = req_valid & ~r_resp_valid;
   assign resp_valid = r_resp_valid;
   assign resp_err   = r_resp_err;
   assign resp_rdata = r_resp_rdata;
   assign DAD        = r_dad;
   assign ddt_o      = r_ddt_o;
   assign ddt_oe     = r_ddt_oe;
   assign MREQ       = r_mreq;
   assign WRITE      = r_bus_write;
   assign SIZE       = r_size;

endmodule

// File: tb/tb_dmem_bus_if.sv
// Directed self-checking bench for dmem_bus_if (XLEN=32, TIMEOUT=15).
module tb_dmem_bus_if;

   logic        clk = 1'b0;
   logic        rst;
   logic        req_valid;
   logic        req_write;
   logic [1:0]  req_size;
   logic        req_unsigned;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        stall;
   logic        resp_valid;
   logic [31:0] resp_rdata;
   logic        resp_err;
   logic [31:0] DAD;
   logic [31:0] ddt_o;
   logic        ddt_oe;
   logic [31:0] ddt_i;
   logic        MREQ;
   logic        WRITE;
   logic [1:0]  SIZE;
   logic        ACKD_n;

   int checks   = 0;
   int failures = 0;
   int n_mreq;
   int guard;

   dmem_bus_if #(.XLEN(32), .AW(32), .TIMEOUT(15)) dut (
      .clk          (clk),
      .rst          (rst),
      .req_valid    (req_valid),
      .req_write    (req_write),
      .req_size     (req_size),
      .req_unsigned (req_unsigned),
      .req_addr     (req_addr),
      .req_wdata    (req_wdata),
      .stall        (stall),
      .resp_valid   (resp_valid),
      .resp_rdata   (resp_rdata),
      .resp_err     (resp_err),
      .DAD          (DAD),
      .ddt_o        (ddt_o),
      .ddt_oe       (ddt_oe),
      .ddt_i        (ddt_i),
      .MREQ         (MREQ),
      .WRITE        (WRITE),
      .SIZE         (SIZE),
      .ACKD_n       (ACKD_n)
   );

   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic put_req(input logic wr, input logic [1:0] sz, input logic uns,
                          input logic [31:0] addr, input logic [31:0] wd);
      req_valid    = 1'b1;
      req_write    = wr;
      req_size     = sz;
      req_unsigned = uns;
      req_addr     = addr;
      req_wdata    = wd;
      #1;
   endtask

   initial begin
      rst = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_size = 2'b00;
      req_unsigned = 1'b0; req_addr = 32'h0; req_wdata = 32'h0;
      ddt_i = 32'h0; ACKD_n = 1'b1;
      tick();
      // reset state
      chk("rst_mreq", MREQ, 1'b0);
      chk("rst_write", {WRITE, ddt_oe}, 2'b00);
      chk("rst_resp", {resp_valid, resp_err}, 2'b00);
      chk("rst_dad", DAD, 32'h0);
      chk("rst_ddt_o", ddt_o, 32'h0);
      chk("rst_size", SIZE, 2'b00);
      chk("rst_rdata", resp_rdata, 32'h0);
      tick();
      rst = 1'b1;
      tick();

      // ACKD_n low while idle must be ignored
      ACKD_n = 1'b0;
      tick();
      chk("idle_ack_mreq", MREQ, 1'b0);
      chk("idle_ack_resp", resp_valid, 1'b0);
      ACKD_n = 1'b1;
      tick();

      // load word 0x100, ack one cycle after MREQ
      put_req(1'b0, 2'b10, 1'b0, 32'h100, 32'h0);
      chk("lw_c0_stall", stall, 1'b1);
      chk("lw_c0_mreq", MREQ, 1'b0);
      tick();
      chk("lw_c1_mreq", MREQ, 1'b1);
      chk("lw_c1_write", WRITE, 1'b0);
      chk("lw_c1_dad", DAD, 32'h100);
      chk("lw_c1_size", SIZE, 2'b10);
      chk("lw_c1_stall", stall, 1'b1);
      chk("lw_c1_resp", resp_valid, 1'b0);
      ACKD_n = 1'b0; ddt_i = 32'hDEADBEEF;
      tick();
      ACKD_n = 1'b1;
      chk("lw_c2_valid", resp_valid, 1'b1);
      chk("lw_c2_rdata", resp_rdata, 32'hDEADBEEF);
      chk("lw_c2_err", resp_err, 1'b0);
      chk("lw_c2_stall", stall, 1'b0);
      chk("lw_c2_mreq", MREQ, 1'b0);
      req_valid = 1'b0;
      tick();
      chk("lw_c3_valid", resp_valid, 1'b0);

      // signed byte load at 0x103
      put_req(1'b0, 2'b00, 1'b0, 32'h103, 32'h0);
      tick();
      chk("lb_dad", DAD, 32'h100);
      chk("lb_size", SIZE, 2'b00);
      ACKD_n = 1'b0; ddt_i = 32'h80FF1234;
      tick();
      ACKD_n = 1'b1;
      chk("lb_valid", resp_valid, 1'b1);
      chk("lb_rdata", resp_rdata, 32'hFFFFFF80);
      req_valid = 1'b0;
      tick();

      // unsigned byte load at 0x103
      put_req(1'b0, 2'b00, 1'b1, 32'h103, 32'h0);
      tick();
      ACKD_n = 1'b0;
      tick();
      ACKD_n = 1'b1;
      chk("lbu_valid", resp_valid, 1'b1);
      chk("lbu_rdata", resp_rdata, 32'h00000080);
      req_valid = 1'b0;
      tick();

      // signed half load at 0x102 (upper half 0x80FF)
      put_req(1'b0, 2'b01, 1'b0, 32'h102, 32'h0);
      tick();
      ACKD_n = 1'b0;
      tick();
      ACKD_n = 1'b1;
      chk("lh_rdata", resp_rdata, 32'hFFFF80FF);
      req_valid = 1'b0;
      tick();

      // store half at 0x102, ack after 3 wait cycles
      put_req(1'b1, 2'b01, 1'b0, 32'h102, 32'h0000ABCD);
      ddt_i = 32'hFFFFFFFF;
      tick();
      chk("sh_ddt_o", ddt_o, 32'hABCDABCD);
      chk("sh_size", SIZE, 2'b01);
      chk("sh_dad", DAD, 32'h100);
      for (int i = 0; i < 4; i++) begin
         chk("sh_write_oe", {MREQ, WRITE, ddt_oe}, 3'b111);
         chk("sh_wait_resp", resp_valid, 1'b0);
         if (i == 3) ACKD_n = 1'b0;
         tick();
      end
      ACKD_n = 1'b1;
      chk("sh_valid", resp_valid, 1'b1);
      chk("sh_err", resp_err, 1'b0);
      chk("sh_rdata", resp_rdata, 32'h0);
      chk("sh_bus_off", {MREQ, WRITE, ddt_oe}, 3'b000);
      req_valid = 1'b0;
      tick();

      // store byte replication
      put_req(1'b1, 2'b00, 1'b0, 32'h201, 32'h000000A5);
      tick();
      chk("sb_ddt_o", ddt_o, 32'hA5A5A5A5);
      ACKD_n = 1'b0;
      tick();
      ACKD_n = 1'b1;
      req_valid = 1'b0;
      tick();

      // misaligned word load at 0x101
      put_req(1'b0, 2'b10, 1'b0, 32'h101, 32'h0);
      tick();
      chk("mis_valid", resp_valid, 1'b1);
      chk("mis_err", resp_err, 1'b1);
      chk("mis_mreq", MREQ, 1'b0);
      chk("mis_rdata", resp_rdata, 32'h0);
      chk("mis_stall", stall, 1'b0);
      req_valid = 1'b0;
      tick();
      chk("mis_after_mreq", MREQ, 1'b0);
      chk("mis_after_valid", resp_valid, 1'b0);

      // double size is illegal on a 32-bit bus
      put_req(1'b0, 2'b11, 1'b0, 32'h100, 32'h0);
      tick();
      chk("dbl_err", {resp_valid, resp_err, MREQ}, 3'b110);
      req_valid = 1'b0;
      tick();

      // timeout with ACKD_n held high
      put_req(1'b0, 2'b10, 1'b0, 32'h200, 32'h0);
      ddt_i = 32'h55555555;
      tick();
      n_mreq = 0;
      guard  = 0;
      while (resp_valid !== 1'b1 && guard < 40) begin
         if (MREQ === 1'b1) n_mreq++;
         tick();
         guard++;
      end
      chk("to_bounded", (guard < 40), 1'b1);
      chk("to_cycles", n_mreq, 15);
      chk("to_err", {resp_valid, resp_err}, 2'b11);
      chk("to_mreq", MREQ, 1'b0);
      chk("to_rdata", resp_rdata, 32'h0);
      req_valid = 1'b0;
      tick();

      // acknowledge on the timeout cycle wins
      put_req(1'b0, 2'b10, 1'b0, 32'h204, 32'h0);
      tick();
      repeat (14) tick();
      chk("to_ack_mreq", MREQ, 1'b1);
      ACKD_n = 1'b0; ddt_i = 32'hCAFEF00D;
      tick();
      ACKD_n = 1'b1;
      chk("to_ack_resp", {resp_valid, resp_err}, 2'b10);
      chk("to_ack_rdata", resp_rdata, 32'hCAFEF00D);
      req_valid = 1'b0;
      tick();

      // reset during a waiting access
      put_req(1'b0, 2'b10, 1'b0, 32'h300, 32'h0);
      tick();
      tick();
      chk("rstm_pre_mreq", MREQ, 1'b1);
      rst = 1'b0;
      #1;
      chk("rstm_mreq", MREQ, 1'b0);
      chk("rstm_valid", resp_valid, 1'b0);
      req_valid = 1'b0;
      tick();
      chk("rstm_hold_valid", resp_valid, 1'b0);
      rst = 1'b1;
      tick();
      chk("rstm_idle_valid", resp_valid, 1'b0);
      put_req(1'b0, 2'b10, 1'b0, 32'h104, 32'h0);
      tick();
      chk("post_rst_mreq", MREQ, 1'b1);
      chk("post_rst_dad", DAD, 32'h104);
      ACKD_n = 1'b0; ddt_i = 32'h12345678;
      tick();
      ACKD_n = 1'b1;
      chk("post_rst_resp", {resp_valid, resp_err}, 2'b10);
      chk("post_rst_rdata", resp_rdata, 32'h12345678);
      req_valid = 1'b0;
      tick();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
